// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and architectural register file.
// It commits valE/valM on each accepted handshake and also holds the halt latch and the retired-instruction counter.
module writeback_regfile #(
    parameter int NREG  = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic             err,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [63:0]      rdA,
    output logic [63:0]      rdB,
    output logic             wb_done,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    logic [63:0]      regs_q [NREG];
    logic             wb_done_q;
    logic             halted_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic             halted_d;

    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       accept;
    logic       bad;
    logic       commit;

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            4'h2: begin
                if (cnd) dst_e = rB;
            end
            4'h3, 4'h6: dst_e = rB;
            4'h5:       dst_m = rA;
            4'h8, 4'h9, 4'hA: dst_e = RRSP;
            4'hB: begin
                dst_e = RRSP;
                dst_m = rA;
            end
            default: ;
        endcase
    end

    // Invalid icodes are handled like a memory error: the core halts and nothing retires.
    assign accept = wb_valid && !halted_q;
    assign bad    = err || (icode > 4'hB);
    assign commit = accept && !bad;

    always_comb begin
        retired_d = retired_q;
        halted_d  = halted_q;
        if (accept) begin
            if (bad) begin
                halted_d = 1'b1;
            end else begin
                retired_d = retired_q + 1'b1;
                if (icode == 4'h0) halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_done_q <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            wb_done_q <= accept;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // When dstE and dstM name the same register, valM wins (popq %rsp).
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [3:0] RID = 4'(gi);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else if (commit) begin
                    if (dst_m == RID) begin
                        regs_q[gi] <= valM;
                    end else if (dst_e == RID) begin
                        regs_q[gi] <= valE;
                    end
                end
            end
        end
    endgenerate

    assign rdA     = (srcA < 4'(NREG)) ? regs_q[srcA] : 64'd0;
    assign rdB     = (srcB < 4'(NREG)) ? regs_q[srcB] : 64'd0;
    assign wb_done = wb_done_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile.
// The stimulus pushes the expected post-commit state, and a monitor pops an entry on every wb_done pulse and checks it.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [3:0]  icode, rA, rB;
    logic        cnd;
    logic [63:0] valE, valM;
    logic        err;
    logic [3:0]  srcA, srcB;
    logic [63:0] rdA, rdB;
    logic        wb_done;
    logic        halted;
    logic [31:0] retired;

    typedef struct {
        logic [31:0] ret;
        logic        halt;
        logic [3:0]  id;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    writeback_regfile #(.NREG(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode),
        .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM), .err(err),
        .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB),
        .wb_done(wb_done), .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm,
                        input logic e, input bit push, input logic [31:0] x_ret,
                        input logic x_halt, input logic [3:0] x_id, input logic [63:0] x_val);
        exp_t x;
        @(negedge clk);
        icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; err = e;
        wb_valid = 1'b1;
        if (push) begin
            x.ret = x_ret; x.halt = x_halt; x.id = x_id; x.val = x_val;
            sb.push_back(x);
        end
        $display("send icode=%h rA=%h rB=%h cnd=%b valE=%0h valM=%0h err=%b", ic, ra, rb, c, ve, vm, e);
    endtask

    task automatic idle();
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic read_a(input string name, input logic [3:0] id, input logic [63:0] expv);
        srcA = id;
        #1;
        check(name, rdA, expv);
    endtask

    // Monitor: every wb_done pulse must match the oldest pending expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (wb_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wb_done: got 1 expected 0 (no pending instruction)");
            end else begin
                e = sb.pop_front();
                srcB = e.id;
                #1;
                check("mon_retired", 64'(retired), 64'(e.ret));
                check("mon_halted", 64'(halted), 64'(e.halt));
                check("mon_reg", rdB, e.val);
                $display("commit checked: retired=%0d halted=%b R[%h]=%0h", retired, halted, e.id, rdB);
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
        cnd = 1'b0; valE = '0; valM = '0; err = 1'b0; srcA = 4'h0; srcB = 4'h0;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) read_a("reset_reg", 4'(i), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        check("reset_wb_done", 64'(wb_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // irmovq: no bypass, so a read in the same cycle sees the old value
        send(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b1, 32'd1, 1'b0, 4'h2, 64'h1234);
        read_a("same_cycle_read", 4'h2, 64'd0);
        idle();
        #1 check("wb_done_pulse", 64'(wb_done), 64'd1);
        read_a("irmovq_R2", 4'h2, 64'h1234);
        idle();
        #1 check("wb_done_single", 64'(wb_done), 64'd0);

        // cmovXX with cnd clear, then set
        send(4'h2, 4'h1, 4'h3, 1'b0, 64'd7, 64'h0, 1'b0, 1'b1, 32'd2, 1'b0, 4'h3, 64'd0);
        send(4'h2, 4'h1, 4'h3, 1'b1, 64'd7, 64'h0, 1'b0, 1'b1, 32'd3, 1'b0, 4'h3, 64'd7);

        // popq %rsp (valM wins), then popq %rcx
        send(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b0, 1'b1, 32'd4, 1'b0, 4'h4, 64'h55);
        send(4'hB, 4'h1, 4'hF, 1'b0, 64'h100, 64'hAA, 1'b0, 1'b1, 32'd5, 1'b0, 4'h1, 64'hAA);
        idle();
        read_a("popq_rsp_valE", 4'h4, 64'h100);

        // OPq and call
        send(4'h6, 4'h1, 4'h5, 1'b0, 64'h77, 64'h0, 1'b0, 1'b1, 32'd6, 1'b0, 4'h5, 64'h77);
        send(4'h8, 4'hF, 4'hF, 1'b0, 64'h200, 64'h0, 1'b0, 1'b1, 32'd7, 1'b0, 4'h4, 64'h200);

        // mrmovq with an address error: halts, with no write and no retirement
        send(4'h5, 4'h5, 4'h1, 1'b0, 64'h0, 64'd9, 1'b1, 1'b1, 32'd7, 1'b1, 4'h5, 64'h77);
        send(4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 4'h0, 64'h0);
        idle();
        #1 check("halted_no_pulse", 64'(wb_done), 64'd0);
        read_a("halted_no_write", 4'h6, 64'd0);
        check("halted_retired", 64'(retired), 64'd7);

        // Async reset while halted clears everything at once
        #1 rst_n = 1'b0;
        #1 check("async_rst_halted", 64'(halted), 64'd0);
        read_a("async_rst_R5", 4'h5, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back instructions with reset asserted before the second edge
        send(4'h3, 4'hF, 4'h7, 1'b0, 64'hA, 64'h0, 1'b0, 1'b1, 32'd1, 1'b0, 4'h7, 64'hA);
        send(4'h3, 4'hF, 4'h8, 1'b0, 64'hB, 64'h0, 1'b0, 1'b0, 32'd0, 1'b0, 4'h0, 64'h0);
        #1 rst_n = 1'b0;
        #1 check("midrst_retired", 64'(retired), 64'd0);
        read_a("midrst_R7", 4'h7, 64'd0);
        @(posedge clk);
        #1 check("midrst_wb_done", 64'(wb_done), 64'd0);
        idle();
        read_a("midrst_R8", 4'h8, 64'd0);
        rst_n = 1'b1;
        send(4'h3, 4'hF, 4'h9, 1'b0, 64'h99, 64'h0, 1'b0, 1'b1, 32'd1, 1'b0, 4'h9, 64'h99);

        // halt counts as retired; reads of F return 0
        send(4'h0, 4'h2, 4'h2, 1'b0, 64'h5, 64'h6, 1'b0, 1'b1, 32'd2, 1'b1, 4'hF, 64'h0);
        idle();
        read_a("halt_no_write", 4'h2, 64'd0);

        // Invalid icode is treated as an error
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(4'hC, 4'h2, 4'h2, 1'b1, 64'h1, 64'h1, 1'b0, 1'b1, 32'd0, 1'b1, 4'h2, 64'h0);
        idle();
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
